// File: rtl/tc_fetch_pkg.sv
// tc_fetch_pkg: shared definitions for the instruction fetch stage.
//   fetch_state_t   : fetch FSM states (FETCH assembling bytes, HOLD offering a word)
//   INSTR_BYTES_DEF : default bytes per instruction word
//   ADDR_W_DEF      : default program address width (256-byte ROM)
//   lane_lsb()      : bit offset of byte lane k within an instruction word
package tc_fetch_pkg;

  localparam int unsigned INSTR_BYTES_DEF = 4;
  localparam int unsigned ADDR_W_DEF      = 8;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Lane k occupies bits [8k+7:8k].
  function automatic int unsigned lane_lsb(input int unsigned k);
    return 8 * k;
  endfunction

endpackage

// File: rtl/tc_fetch_unit8.sv
// tc_fetch_unit8: instruction fetch stage in front of the 8-bit program ROM.
// Owns the program counter, reads one ROM byte per cycle and assembles
// INSTR_BYTES consecutive bytes (little-endian) into an instruction word that
// is offered to the decoder over a valid/ready handshake.
//   clk, rst     : clock, synchronous active-high reset
//   prog_addr    : ROM byte address (registered state only)
//   prog_data    : ROM read data for prog_addr, same cycle
//   instr        : assembled instruction, byte at instr_pc in [7:0]
//   instr_pc     : address of the first byte of instr
//   instr_valid  : instr/instr_pc hold a complete instruction
//   instr_ready  : decoder accepts the instruction this cycle
//   jump_valid   : redirect request, jump_target is the new pc
//   stall        : freezes fetch, assembly and the handshake
module tc_fetch_unit8
  import tc_fetch_pkg::*;
#(
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        prog_addr,
  input  logic [7:0]               prog_data,
  output logic [8*INSTR_BYTES-1:0] instr,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     jump_valid,
  input  logic [ADDR_W-1:0]        jump_target,
  input  logic                     stall
);

  localparam int unsigned      IDX_W    = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTR_BYTES - 1);

  logic [ADDR_W-1:0]        pc;
  logic [IDX_W-1:0]         idx;
  fetch_state_t             state;
  logic [8*INSTR_BYTES-1:0] lanes;
  logic [ADDR_W-1:0]        pc_q;
  logic                     valid_q;
  logic                     accept;

  // Stall masks ready so a stalled valid&ready is never a transfer.
  assign accept = valid_q & instr_ready & ~stall;

  // idx is always 0 in HOLD, so this also yields prog_addr = pc there.
  assign prog_addr   = pc + ADDR_W'(idx);
  assign instr       = lanes;
  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      idx     <= '0;
      state   <= FETCH;
      lanes   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (jump_valid) begin
      // Lanes and instr_pc are left as-is; they are don't-care while invalid.
      pc      <= jump_target;
      idx     <= '0;
      state   <= FETCH;
      valid_q <= 1'b0;
    end else if (!stall) begin
      case (state)
        FETCH: begin
          for (int unsigned k = 0; k < INSTR_BYTES; k++) begin
            if (idx == IDX_W'(k)) lanes[lane_lsb(k) +: 8] <= prog_data;
          end
          if (idx == LAST_IDX) begin
            valid_q <= 1'b1;
            pc_q    <= pc;
            idx     <= '0;
            state   <= HOLD;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        HOLD: begin
          if (accept) begin
            pc      <= pc + ADDR_W'(INSTR_BYTES);
            valid_q <= 1'b0;
            state   <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_fetch_unit8.sv
// tb_tc_fetch_unit8: self-checking bench for tc_fetch_unit8 with a 256-byte
// ROM model. Directed scenarios follow the fetch stage's documented behaviour;
// a randomized run checks every transfer against the ROM contents.
module tb_tc_fetch_unit8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_valid;
  logic [7:0]  jump_target;
  logic        stall;

  logic [7:0]  rom [0:255];

  int checks = 0;
  int errors = 0;

  tc_fetch_unit8 #(.INSTR_BYTES(4), .ADDR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .stall       (stall)
  );

  assign prog_data = rom[prog_addr];

  always #5 clk = ~clk;

  // Four ROM bytes starting at a, wrapping at 0xFF, little-endian.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    logic [31:0] w;
    logic [7:0]  x;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      x = a + 8'(b);
      w[8*b +: 8] = rom[x];
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; jump_valid = 1'b0; stall = 1'b0; instr_ready = 1'b0; jump_target = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 8'h00 || prog_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset: valid=%b instr=%h pc=%h addr=%h, want 0/0/0/0",
               instr_valid, instr, instr_pc, prog_addr);
    end
  endtask

  task automatic test_first_fetch();
    int n;
    do_reset();
    instr_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (instr_valid !== 1'b0 || prog_addr !== 8'(c)) begin
        errors++;
        $display("FAIL first_fetch_cycle%0d: valid=%b addr=%h, want 0/%h", c, instr_valid, prog_addr, 8'(c));
      end
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h03020100 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL first_instr: valid=%b instr=%h pc=%h, want 1/03020100/00", instr_valid, instr, instr_pc);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (instr_valid !== 1'b1 && n < 20);
    checks++;
    if (n != 5 || instr !== 32'h07060504 || instr_pc !== 8'h04) begin
      errors++;
      $display("FAIL second_instr: cycles=%0d instr=%h pc=%h, want 5/07060504/04", n, instr, instr_pc);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_hold_backpressure();
    do_reset();
    for (int c = 0; c < 4; c++) step();
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h03020100 || prog_addr !== 8'h00) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b instr=%h addr=%h, want 1/03020100/00", c, instr_valid, instr, prog_addr);
      end
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || prog_addr !== 8'h04) begin
      errors++;
      $display("FAIL hold_release: valid=%b addr=%h, want 0/04", instr_valid, prog_addr);
    end
  endtask

  task automatic test_jump_mid();
    do_reset();
    step();
    step();
    jump_valid = 1'b1; jump_target = 8'h40;
    step();
    jump_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (instr_valid !== 1'b0 || prog_addr !== 8'(8'h40 + c)) begin
        errors++;
        $display("FAIL jump_mid_addr%0d: valid=%b addr=%h, want 0/%h", c, instr_valid, prog_addr, 8'(8'h40 + c));
      end
      step();
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h43424140 || instr_pc !== 8'h40) begin
      errors++;
      $display("FAIL jump_mid_instr: valid=%b instr=%h pc=%h, want 1/43424140/40", instr_valid, instr, instr_pc);
    end
  endtask

  // Continues from test_jump_mid: a word at 0x40 is being offered.
  task automatic test_jump_handshake();
    int xfers;
    xfers = 0;
    instr_ready = 1'b1; jump_valid = 1'b1; jump_target = 8'h10;
    if (instr_valid && instr_ready && !stall) xfers++;
    step();
    instr_ready = 1'b0; jump_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (instr_valid && instr_ready && !stall) xfers++;
      step();
    end
    checks++;
    if (xfers != 1 || instr_valid !== 1'b1 || instr_pc !== 8'h10 || instr !== 32'h13121110) begin
      errors++;
      $display("FAIL jump_handshake: xfers=%0d valid=%b pc=%h instr=%h, want 1/1/10/13121110",
               xfers, instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    do_reset();
    jump_valid = 1'b1; jump_target = 8'hFE;
    step();
    jump_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (prog_addr !== exp_a[c]) begin
        errors++;
        $display("FAIL wrap_addr%0d: addr=%h, want %h", c, prog_addr, exp_a[c]);
      end
      step();
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'hFE || instr !== 32'h0100FFFE) begin
      errors++;
      $display("FAIL wrap_instr: valid=%b pc=%h instr=%h, want 1/FE/0100FFFE", instr_valid, instr_pc, instr);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (prog_addr !== 8'h02 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_accept: addr=%h valid=%b, want 02/0", prog_addr, instr_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    instr_ready = 1'b1;
    step();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (prog_addr !== 8'h01 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_fetch%0d: addr=%h valid=%b, want 01/0", c, prog_addr, instr_valid);
      end
    end
    stall = 1'b0;
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h03020100 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL stall_word: valid=%b instr=%h pc=%h, want 1/03020100/00", instr_valid, instr, instr_pc);
    end
    // Stall in HOLD with ready high must not transfer.
    stall = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || prog_addr !== 8'h00 || instr !== 32'h03020100) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b addr=%h instr=%h, want 1/00/03020100", c, instr_valid, prog_addr, instr);
      end
    end
    stall = 1'b0;
    step();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || prog_addr !== 8'h04) begin
      errors++;
      $display("FAIL stall_release: valid=%b addr=%h, want 0/04", instr_valid, prog_addr);
    end
  endtask

  task automatic test_rst_in_hold();
    do_reset();
    jump_valid = 1'b1; jump_target = 8'h20;
    step();
    jump_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || prog_addr !== 8'h00 || instr_pc !== 8'h00 || instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_hold: valid=%b addr=%h pc=%h instr=%h, want 0/00/00/0",
               instr_valid, prog_addr, instr_pc, instr);
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp_pc;
    int          xfers;
    logic        pv, hs, jmp, stl;
    logic [31:0] pinstr;
    logic [7:0]  ppc, paddr, tgt;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    do_reset();
    exp_pc = 8'h00;
    xfers  = 0;
    for (int c = 0; c < 3000; c++) begin
      stl = ($urandom_range(0, 99) < 15);
      jmp = ($urandom_range(0, 99) < 5);
      tgt = 8'($urandom);
      instr_ready = ($urandom_range(0, 99) < 70);
      stall = stl; jump_valid = jmp; jump_target = tgt;
      hs = instr_valid & instr_ready & ~stl;
      pv = instr_valid; pinstr = instr; ppc = instr_pc; paddr = prog_addr;
      if (hs) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
          errors++;
          $display("FAIL rand_xfer%0d: pc=%h instr=%h, want %h/%h", xfers, instr_pc, instr, exp_pc, rom_word(exp_pc));
        end
        exp_pc = exp_pc + 8'd4;
        xfers++;
      end
      if (jmp) exp_pc = tgt;
      step();
      if (jmp) begin
        checks++;
        if (instr_valid !== 1'b0 || prog_addr !== tgt) begin
          errors++;
          $display("FAIL rand_jump@%0d: valid=%b addr=%h, want 0/%h", c, instr_valid, prog_addr, tgt);
        end
      end else if (stl) begin
        checks++;
        if (instr_valid !== pv || prog_addr !== paddr || instr !== pinstr) begin
          errors++;
          $display("FAIL rand_stall@%0d: valid=%b addr=%h instr=%h, want %b/%h/%h",
                   c, instr_valid, prog_addr, instr, pv, paddr, pinstr);
        end
      end else if (pv && !hs) begin
        checks++;
        if (instr_valid !== 1'b1 || instr !== pinstr || instr_pc !== ppc) begin
          errors++;
          $display("FAIL rand_hold@%0d: valid=%b instr=%h pc=%h, want 1/%h/%h", c, instr_valid, instr, instr_pc, pinstr, ppc);
        end
      end
    end
    jump_valid = 1'b0; stall = 1'b0; instr_ready = 1'b0;
    checks++;
    if (xfers < 100) begin
      errors++;
      $display("FAIL rand_progress: transfers=%0d, want >=100", xfers);
    end
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b0; jump_valid = 1'b0; jump_target = '0; stall = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    test_reset();
    test_first_fetch();
    test_hold_backpressure();
    test_jump_mid();
    test_jump_handshake();
    test_wrap();
    test_stall();
    test_rst_in_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tc_fetch_unit8.md
# tc_fetch_unit8

Instruction fetch stage that sits directly upstream of the 8-bit program ROM: it owns the program counter, drives the ROM address one byte per cycle, and assembles consecutive bytes into a 32-bit instruction word. The assembled instruction goes to the decoder over a valid/ready handshake. Redirects from the execute stage (jumps) flush any partially assembled instruction, and a stall input freezes fetch.

## Interface
- INSTR_BYTES, 4, bytes per instruction word; legal values 1..4.
- ADDR_W, 8, program address width; matches the 256-byte program ROM.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- prog_addr  out  ADDR_W  byte address to the program ROM; purely a function of registered state.
- prog_data  in  8  ROM read data, combinational from prog_addr in the same cycle.
- instr  out  8*INSTR_BYTES  assembled instruction, little-endian: byte at pc in [7:0].
- instr_pc  out  ADDR_W  address of the first byte of instr.
- instr_valid  out  1  instr/instr_pc hold a complete instruction.
- instr_ready  in  1  decoder accepts the instruction this cycle.
- jump_valid  in  1  redirect request.
- jump_target  in  ADDR_W  new pc when jump_valid is high.
- stall  in  1  level; freeze fetch and assembly.

## Operation
- Registers:
  - pc: ADDR_W bits.
  - idx: byte index, 0..INSTR_BYTES-1.
  - state: FETCH or HOLD.
  - byte lanes of instr.
  - instr_valid.
- prog_addr = (pc + idx) mod 2^ADDR_W. Wrap 0xFF -> 0x00 is legal, with no error.
- FETCH:
  - Each cycle, capture prog_data into lane idx.
  - If idx < INSTR_BYTES-1, then idx++.
  - Otherwise set instr_valid=1, instr_pc=pc, idx=0, and go to HOLD.
- HOLD:
  - prog_addr = pc; no capture.
  - On instr_valid & instr_ready: pc += INSTR_BYTES (mod 2^ADDR_W), instr_valid=0, go to FETCH.
- Priority per cycle, highest first: rst > jump_valid > stall > normal FETCH/HOLD behaviour.
- jump_valid:
  - pc=jump_target, idx=0, instr_valid=0, state=FETCH.
  - Lanes are not cleared; the stale contents are don't-care.
  - Jump in the same cycle as an accepted handshake: the handshake counts as consumed (the decoder keeps that instruction), and pc takes jump_target, not pc+INSTR_BYTES.
  - Jump while stall=1: the jump still applies.
- stall=1 with no jump:
  - All registers hold; prog_addr holds its value.
  - instr_valid holds and the handshake is ignored, so no acceptance occurs.
  - Required: the decoder must not treat valid&ready during a stall as a transfer. Stall masks ready internally.
- instr_valid must not drop without a handshake, a jump or rst.
- instr and instr_pc must be stable while instr_valid=1.

## Timing
- Reset values: pc=0, idx=0, state=FETCH, instr_valid=0, instr=0, instr_pc=0, prog_addr=0.
- rst asserted mid-assembly or in HOLD: all registers return to the reset values on that edge; partial bytes are discarded.
- Latency, from leaving reset (or from a jump edge) to instr_valid=1: INSTR_BYTES cycles.
- Throughput with instr_ready tied high: one instruction per INSTR_BYTES+1 cycles (one HOLD cycle per instruction).
- ROM path: prog_addr (from registers) -> ROM -> prog_data -> lane capture must close within one cycle.
- No combinational path from any input to prog_addr.
- The only combinational input-to-output dependence is none; all outputs are registered or derived from registers.

## Structure
- Shared package tc_fetch_pkg holds:
  - the state enum {FETCH, HOLD};
  - the default INSTR_BYTES and ADDR_W constants;
  - the lane-select function (lane k = bits [8k+7:8k]).
- Single module with no sub-module: the FSM, pc and lane registers are tightly coupled and small.
- Testbenches instantiate it against the existing program ROM model loaded with a known byte file.

## Test plan
- Reset then release, ROM bytes 00..0F = 0x00..0x0F, instr_ready=1 -> first instr=0x03020100, instr_pc=0x00, valid on cycle 4 after reset; next instr=0x07060504, instr_pc=0x04.
- instr_ready=0 for 10 cycles in HOLD -> instr_valid stays 1, instr stays constant, prog_addr=pc; ready=1 -> pc advances by 4 on the next edge.
- jump_valid with target 0x40 while idx=2 -> next cycles prog_addr=0x40,0x41,0x42,0x43; instr = bytes 0x40..0x43 little-endian, instr_pc=0x40.
- Handshake and jump to 0x10 in the same cycle -> exactly one transfer counted; next instr_pc=0x10.
- jump to 0xFE -> prog_addr sequence FE,FF,00,01; instr_pc=0xFE; after acceptance pc=0x02.
- stall=1 for 3 cycles mid-fetch at idx=1 -> no register changes and prog_addr constant; after stall drops, the assembled word equals an unstalled fetch.
- rst pulse in HOLD -> instr_valid=0 and pc=0 on the next edge.
